// File: rtl/pe_xnor_seq_ctrl_if.sv
// Job/datapath bundle between the layer scheduler, the PE sequencer and the
// act/weight buffers. master = scheduler/datapath side, slave = sequencer.
interface pe_xnor_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int PSUM_W = 10,
  parameter int ACC_W  = 20
);
  logic              i_start;
  logic              i_abort;
  logic [ADDR_W-1:0] i_len;
  logic [ADDR_W-1:0] i_base_act;
  logic [ADDR_W-1:0] i_base_wgt;
  logic              i_bin;
  logic              i_signI;
  logic              o_busy;
  logic              o_buf_re;
  logic [ADDR_W-1:0] o_act_addr;
  logic [ADDR_W-1:0] o_wgt_addr;
  logic              o_pe_bin;
  logic              o_pe_signI;
  logic [PSUM_W-1:0] i_psum;
  logic [ACC_W-1:0]  o_acc;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output i_start, i_abort, i_len, i_base_act, i_base_wgt, i_bin, i_signI,
    output i_psum, i_ready,
    input  o_busy, o_buf_re, o_act_addr, o_wgt_addr, o_pe_bin, o_pe_signI,
    input  o_acc, o_valid
  );

  modport slave (
    input  i_start, i_abort, i_len, i_base_act, i_base_wgt, i_bin, i_signI,
    input  i_psum, i_ready,
    output o_busy, o_buf_re, o_act_addr, o_wgt_addr, o_pe_bin, o_pe_signI,
    output o_acc, o_valid
  );
endinterface

// File: rtl/pe_xnor_seq_ctrl.sv
// Job sequencer for one xnor PE: streams LEN buffer reads, accumulates the
// sign-extended PE partial sums and returns the total over valid/ready.
module pe_xnor_seq_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int PSUM_W  = 10,
  parameter int ACC_W   = 20,
  parameter int BUF_LAT = 1,
  parameter int PE_LAT  = 1
) (
  input logic               CLK,
  input logic               RSTn,
  pe_xnor_seq_ctrl_if.slave bus
);
  localparam int LAT = BUF_LAT + PE_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state_reg;
  logic [ADDR_W-1:0]        remain_reg;
  logic [ADDR_W-1:0]        act_addr_reg;
  logic [ADDR_W-1:0]        wgt_addr_reg;
  logic                     buf_re_reg;
  logic                     pe_bin_reg;
  logic                     pe_sign_reg;
  logic                     valid_reg;
  logic                     busy_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [LAT-1:0]           vld_sr_reg;
  logic [LAT-1:0]           vld_sr_next;
  logic signed [ACC_W-1:0]  psum_ext;
  logic                     sr_tail_empty;

  assign psum_ext = {{(ACC_W-PSUM_W){bus.i_psum[PSUM_W-1]}}, bus.i_psum};

  // Bit k of the shift register marks a read issued k+1 cycles ago.
  assign vld_sr_next[0] = buf_re_reg;
  for (genvar gi = 1; gi < LAT; gi++) begin : g_sr
    assign vld_sr_next[gi] = vld_sr_reg[gi-1];
  end

  // Only the oldest bit left means the final psum lands on this edge.
  if (LAT > 1) begin : g_tail
    assign sr_tail_empty = (vld_sr_reg[LAT-2:0] == '0);
  end else begin : g_tail
    assign sr_tail_empty = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg    <= IDLE;
      remain_reg   <= '0;
      act_addr_reg <= '0;
      wgt_addr_reg <= '0;
      buf_re_reg   <= 1'b0;
      pe_bin_reg   <= 1'b0;
      pe_sign_reg  <= 1'b0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      acc_reg      <= '0;
      vld_sr_reg   <= '0;
    end else begin
      vld_sr_reg <= vld_sr_next;
      if (vld_sr_reg[LAT-1]) begin
        acc_reg <= acc_reg + psum_ext;
      end

      if (state_reg != IDLE && bus.i_abort) begin
        state_reg   <= IDLE;
        vld_sr_reg  <= '0;
        acc_reg     <= '0;
        buf_re_reg  <= 1'b0;
        valid_reg   <= 1'b0;
        busy_reg    <= 1'b0;
        pe_bin_reg  <= 1'b0;
        pe_sign_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.i_start && !bus.i_abort) begin
              acc_reg      <= '0;
              busy_reg     <= 1'b1;
              act_addr_reg <= bus.i_base_act;
              wgt_addr_reg <= bus.i_base_wgt;
              remain_reg   <= bus.i_len - ADDR_W'(1);
              if (bus.i_len != '0) begin
                state_reg   <= ISSUE;
                buf_re_reg  <= 1'b1;
                pe_bin_reg  <= bus.i_bin;
                pe_sign_reg <= bus.i_signI;
              end else begin
                state_reg <= DONE;
                valid_reg <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (remain_reg == '0) begin
              state_reg  <= DRAIN;
              buf_re_reg <= 1'b0;
            end else begin
              remain_reg   <= remain_reg - ADDR_W'(1);
              act_addr_reg <= act_addr_reg + ADDR_W'(1);
              wgt_addr_reg <= wgt_addr_reg + ADDR_W'(1);
            end
          end
          DRAIN: begin
            if (sr_tail_empty) begin
              state_reg   <= DONE;
              valid_reg   <= 1'b1;
              pe_bin_reg  <= 1'b0;
              pe_sign_reg <= 1'b0;
            end
          end
          DONE: begin
            if (bus.i_ready) begin
              state_reg <= IDLE;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_busy     = busy_reg;
  assign bus.o_buf_re   = buf_re_reg;
  assign bus.o_act_addr = act_addr_reg;
  assign bus.o_wgt_addr = wgt_addr_reg;
  assign bus.o_pe_bin   = pe_bin_reg;
  assign bus.o_pe_signI = pe_sign_reg;
  assign bus.o_acc      = acc_reg;
  assign bus.o_valid    = valid_reg;
endmodule

// File: tb/tb_pe_xnor_seq_ctrl.sv
// Bench for pe_xnor_seq_ctrl: directed vector table, hand-written corner
// sequences and random jobs, with a buffer+PE stand-in feeding psums back.
module tb_pe_xnor_seq_ctrl;
  localparam int ADDR_W  = 8;
  localparam int PSUM_W  = 10;
  localparam int ACC_W   = 20;
  localparam int BUF_LAT = 1;
  localparam int PE_LAT  = 1;
  localparam int L       = BUF_LAT + PE_LAT;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [PSUM_W-1:0] psum_mem [256];

  pe_xnor_seq_ctrl_if #(.ADDR_W(ADDR_W), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

  pe_xnor_seq_ctrl #(
    .ADDR_W(ADDR_W), .PSUM_W(PSUM_W), .ACC_W(ACC_W),
    .BUF_LAT(BUF_LAT), .PE_LAT(PE_LAT)
  ) dut (
    .CLK (clk),
    .RSTn(rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer + PE stand-in: a read seen in cycle t returns psum_mem[addr] in cycle t+L.
  typedef struct {
    logic              re;
    logic [ADDR_W-1:0] addr;
  } rd_t;
  rd_t hist[$];

  always @(negedge clk) begin : pe_model
    rd_t s;
    s.re   = bus.o_buf_re;
    s.addr = bus.o_act_addr;
    hist.push_back(s);
    while (hist.size() > L + 1) void'(hist.pop_front());
    if (hist.size() == L + 1 && hist[0].re) bus.i_psum = psum_mem[hist[0].addr];
    else bus.i_psum = PSUM_W'($urandom);
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: plain sum of the psums at the LEN consecutive (wrapping) addresses.
  function automatic logic [ACC_W-1:0] model_sum(input int len, input int base);
    longint sum = 0;
    for (int k = 0; k < len; k++) sum += longint'($signed(psum_mem[(base + k) % 256]));
    return ACC_W'(sum);
  endfunction

  task automatic run_job(input logic [7:0] len, input logic [7:0] act, input logic [7:0] wgt,
                         input logic bin, input logic sgn, input int wait_n,
                         input logic [ACC_W-1:0] exp_acc, input int exp_cyc);
    int cyc = 0;
    int nreads = 0;
    bit got_valid = 0;
    bus.i_len      = len;
    bus.i_base_act = act;
    bus.i_base_wgt = wgt;
    bus.i_bin      = bin;
    bus.i_signI    = sgn;
    bus.i_abort    = 1'b0;
    bus.i_ready    = (wait_n == 0);
    bus.i_start    = 1'b1;
    while (!got_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.i_start = 1'b0;
      if (bus.o_buf_re) begin
        check("read_cycle", 64'(cyc), 64'(nreads + 1));
        check("act_addr", 64'(bus.o_act_addr), 64'(8'(act + nreads)));
        check("wgt_addr", 64'(bus.o_wgt_addr), 64'(8'(wgt + nreads)));
        check("pe_mode", 64'({bus.o_pe_bin, bus.o_pe_signI}), 64'({bin, sgn}));
        nreads++;
      end
      if (bus.o_valid) got_valid = 1;
      else check("busy", 64'(bus.o_busy), 64'(1));
    end
    check("valid_seen", 64'(got_valid), 64'(1));
    check("valid_cycle", 64'(cyc), 64'(exp_cyc));
    check("read_count", 64'(nreads), 64'(len));
    check("acc", 64'(bus.o_acc), 64'(exp_acc));
    if (got_valid) begin
      if (wait_n == 0) begin
        @(negedge clk);
        check("valid_pulse", 64'(bus.o_valid), 64'(0));
        check("idle_after", 64'(bus.o_busy), 64'(0));
      end else begin
        for (int w = 0; w < wait_n; w++) begin
          bus.i_start = (w % 2 == 0);
          bus.i_len   = 8'($urandom);
          @(negedge clk);
          check("valid_hold", 64'(bus.o_valid), 64'(1));
          check("acc_hold", 64'(bus.o_acc), 64'(exp_acc));
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 64'(bus.o_valid), 64'(0));
        check("idle_after_ready", 64'(bus.o_busy), 64'(0));
      end
    end
    bus.i_ready = 1'b0;
    bus.i_start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] len;
    logic [7:0] act;
    logic [7:0] wgt;
    logic       bin;
    logic       sgn;
    int         wait_n;
    int         fill;
    int         p0, p1, p2, p3;
    int         exp_acc;
    int         exp_cyc;
  } vec_t;
  vec_t vecs[5];

  initial begin : main
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{8'd4,   8'h10, 8'h20, 1'b1, 1'b0, 0, 0,    3,    -1,   5,    2,    9,       4 + L + 1};
    vecs[1] = '{8'd0,   8'h33, 8'h44, 1'b0, 1'b1, 0, 7,    7,    7,    7,    7,    0,       1};
    vecs[2] = '{8'd3,   8'hFE, 8'h05, 1'b0, 1'b1, 1, 0,    10,   -20,  100,  77,   90,      3 + L + 1};
    vecs[3] = '{8'd255, 8'h00, 8'h80, 1'b1, 1'b1, 0, -512, -512, -512, -512, -512, -130560, 255 + L + 1};
    vecs[4] = '{8'd5,   8'h70, 8'h71, 1'b1, 1'b0, 5, 9,    -3,   4,    -5,   6,    11,      5 + L + 1};

    rst_n          = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_abort    = 1'b0;
    bus.i_len      = '0;
    bus.i_base_act = '0;
    bus.i_base_wgt = '0;
    bus.i_bin      = 1'b0;
    bus.i_signI    = 1'b0;
    bus.i_ready    = 1'b0;
    for (int i = 0; i < 256; i++) psum_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.o_busy), 64'(0));
    check("rst_buf_re", 64'(bus.o_buf_re), 64'(0));
    check("rst_valid", 64'(bus.o_valid), 64'(0));
    check("rst_acc", 64'(bus.o_acc), 64'(0));
    check("rst_addr", 64'({bus.o_act_addr, bus.o_wgt_addr}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      for (int a = 0; a < 256; a++) psum_mem[a] = PSUM_W'(vecs[i].fill);
      psum_mem[8'(vecs[i].act + 8'd0)] = PSUM_W'(vecs[i].p0);
      psum_mem[8'(vecs[i].act + 8'd1)] = PSUM_W'(vecs[i].p1);
      psum_mem[8'(vecs[i].act + 8'd2)] = PSUM_W'(vecs[i].p2);
      psum_mem[8'(vecs[i].act + 8'd3)] = PSUM_W'(vecs[i].p3);
      run_job(vecs[i].len, vecs[i].act, vecs[i].wgt, vecs[i].bin, vecs[i].sgn,
              vecs[i].wait_n, ACC_W'(vecs[i].exp_acc), vecs[i].exp_cyc);
      @(negedge clk);
    end

    // Abort in the second ISSUE cycle, then a clean follow-up job
    for (int a = 0; a < 256; a++) psum_mem[a] = PSUM_W'(1);
    bus.i_len = 8'd6; bus.i_base_act = 8'h40; bus.i_base_wgt = 8'h50;
    bus.i_ready = 1'b1; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("abort_pre_re", 64'(bus.o_buf_re), 64'(1));
    @(negedge clk);
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    check("abort_busy", 64'(bus.o_busy), 64'(0));
    check("abort_re", 64'(bus.o_buf_re), 64'(0));
    begin
      bit seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.o_valid) seen = 1;
      end
      check("abort_no_valid", 64'(seen), 64'(0));
    end
    bus.i_ready = 1'b0;
    run_job(8'd2, 8'h40, 8'h50, 1'b0, 1'b0, 0, ACC_W'(2), 2 + L + 1);

    // Abort together with start in IDLE: nothing starts
    bus.i_len = 8'd3; bus.i_start = 1'b1; bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    check("abort_start_busy", 64'(bus.o_busy), 64'(0));
    @(negedge clk);

    // Abort while waiting in DONE drops the result
    bus.i_len = 8'd1; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    begin
      int c = 0;
      while (!bus.o_valid && c < 50) begin
        @(negedge clk);
        c++;
      end
      check("done_reached", 64'(bus.o_valid), 64'(1));
    end
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    check("done_abort_valid", 64'(bus.o_valid), 64'(0));
    check("done_abort_busy", 64'(bus.o_busy), 64'(0));

    // Reset pulse mid-ISSUE
    for (int a = 0; a < 256; a++) psum_mem[a] = PSUM_W'(5);
    bus.i_len = 8'd10; bus.i_base_act = 8'h21; bus.i_base_wgt = 8'h31;
    bus.i_bin = 1'b1; bus.i_signI = 1'b1; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(bus.o_busy), 64'(0));
    check("mrst_re", 64'(bus.o_buf_re), 64'(0));
    check("mrst_addr", 64'({bus.o_act_addr, bus.o_wgt_addr}), 64'(0));
    check("mrst_mode", 64'({bus.o_pe_bin, bus.o_pe_signI}), 64'(0));
    check("mrst_acc", 64'(bus.o_acc), 64'(0));
    check("mrst_valid", 64'(bus.o_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle", 64'(bus.o_busy), 64'(0));

    // Random jobs against the summing model
    for (int j = 0; j < 25; j++) begin
      int   len;
      int   act;
      int   wgt;
      logic [ACC_W-1:0] ea;
      for (int a = 0; a < 256; a++) psum_mem[a] = PSUM_W'($urandom);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      act = int'($urandom_range(0, 255));
      wgt = int'($urandom_range(0, 255));
      ea  = model_sum(len, act);
      run_job(8'(len), 8'(act), 8'(wgt), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), ea, (len == 0) ? 1 : len + L + 1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
